uart_receiver: RTL and testbench

Serial-to-parallel UART receive engine, the receive-side counterpart of the team's UART transmitter. It converts an asynchronous 8N1 serial line into bytes. The line is oversampled at 16× baud using a system-clock enable, and each byte is held in a single-entry holding register with empty, overrun and framing-error status. It sits between the board RX pin and the register/bus interface that unloads received bytes.

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_receiver_if.sv | 27 ++
 rtl/uart_sync2.sv | 22 ++
 rtl/uart_receiver.sv | 137 +++++++++++++
 tb/tb_uart_receiver.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and the frame geometry
// that the transmitter and receiver both use.
package uart_pkg;
  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_DATA_BITS  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_rx_state_t;
endpackage

// File: rtl/uart_receiver_if.sv
// Receiver-side signal bundle: serial line, oversample tick, unload request
// and the holding-register status seen by the bus side.
interface uart_receiver_if
  import uart_pkg::*;
#(
  parameter int DATA_BITS = UART_DATA_BITS
) ();
  logic                 i_clk_en;
  logic                 i_rx;
  logic                 i_rx_en;
  logic                 i_uld_rx_data;
  logic [DATA_BITS-1:0] o_rx_data;
  logic                 o_rx_empty;
  logic                 o_rx_frame_err;
  logic                 o_rx_overrun;
  logic                 o_rx_busy;

  modport master (
    output i_clk_en, i_rx, i_rx_en, i_uld_rx_data,
    input  o_rx_data, o_rx_empty, o_rx_frame_err, o_rx_overrun, o_rx_busy
  );

  modport slave (
    input  i_clk_en, i_rx, i_rx_en, i_uld_rx_data,
    output o_rx_data, o_rx_empty, o_rx_frame_err, o_rx_overrun, o_rx_busy
  );
endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input; the reset
// value is a parameter so idle-high and idle-low lines can both use it.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receive engine: 16x oversampled start/data/stop sampling into a
// single-entry holding register with sticky overrun and framing-error flags.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int DATA_BITS  = UART_DATA_BITS
) (
  input  logic            i_sys_clk,
  input  logic            i_rst_n,
  uart_receiver_if.slave  rx_if
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  uart_rx_state_t       state;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 rx_s, rx_prev, busy;
  logic [DATA_BITS-1:0] data;
  logic                 empty, frame_err, overrun;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk   (i_sys_clk),
    .rst_n (i_rst_n),
    .d     (rx_if.i_rx),
    .q     (rx_s)
  );

  logic half_bit, full_bit, stop_tick, frame_ok, frame_bad, unload;
  assign half_bit  = (cnt == CW'(OVERSAMPLE/2 - 1));
  assign full_bit  = (cnt == CW'(OVERSAMPLE - 1));
  assign stop_tick = rx_if.i_clk_en && rx_if.i_rx_en && (state == STOP) && full_bit;
  assign frame_ok  = stop_tick && rx_s;
  assign frame_bad = stop_tick && !rx_s;
  assign unload    = rx_if.i_uld_rx_data && !empty;

  // rx_prev tracks the line on every tick, not just in IDLE, so a line that
  // stays low past a bad stop bit cannot fake a fresh falling edge.
  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      rx_prev <= 1'b1;
      busy    <= 1'b0;
    end else if (rx_if.i_clk_en) begin
      rx_prev <= rx_s;
      if (!rx_if.i_rx_en) begin
        state   <= IDLE;
        cnt     <= '0;
        bit_idx <= '0;
        busy    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (rx_prev && !rx_s) begin
              state <= START;
              cnt   <= '0;
              busy  <= 1'b1;
            end
          end
          START: begin
            if (half_bit) begin
              cnt     <= '0;
              bit_idx <= '0;
              state   <= rx_s ? IDLE : DATA;
              busy    <= !rx_s;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          DATA: begin
            if (full_bit) begin
              cnt   <= '0;
              shreg <= {rx_s, shreg[DATA_BITS-1:1]};
              if (bit_idx == BW'(DATA_BITS - 1)) begin
                state   <= STOP;
                bit_idx <= '0;
              end else begin
                bit_idx <= bit_idx + BW'(1);
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          STOP: begin
            if (full_bit) begin
              state <= IDLE;
              cnt   <= '0;
              busy  <= 1'b0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Holding register runs every cycle so unload never waits for a tick;
  // a flag raised in the unload cycle takes priority over the clear.
  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      data      <= '0;
      empty     <= 1'b1;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (frame_ok && (empty || unload)) begin
        data  <= shreg;
        empty <= 1'b0;
      end else if (unload) begin
        empty <= 1'b1;
      end

      if (frame_bad)   frame_err <= 1'b1;
      else if (unload) frame_err <= 1'b0;

      if (frame_ok && !empty && !unload) overrun <= 1'b1;
      else if (unload)                   overrun <= 1'b0;
    end
  end

  assign rx_if.o_rx_data      = data;
  assign rx_if.o_rx_empty     = empty;
  assign rx_if.o_rx_frame_err = frame_err;
  assign rx_if.o_rx_overrun   = overrun;
  assign rx_if.o_rx_busy      = busy;
endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboarded bench for uart_receiver: directed scenarios plus random 8N1
// frames, checked against a holding-register model driven by frame outcomes.
module tb_uart_receiver;
  import uart_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_receiver_if ifc ();

  uart_receiver dut (
    .i_sys_clk (clk),
    .i_rst_n   (rst_n),
    .rx_if     (ifc.slave)
  );

  int total = 0;
  int bad = 0;
  int tick_cnt = 0;
  int frame_s = -1;
  bit mon_on = 1'b0;

  // One tick every 4 system clocks, changed on the falling edge.
  initial begin
    int div;
    div = 0;
    ifc.i_clk_en = 1'b0;
    forever begin
      @(negedge clk);
      div = (div + 1) % 4;
      ifc.i_clk_en = (div == 0);
    end
  end

  always @(posedge clk) if (ifc.i_clk_en) tick_cnt <= tick_cnt + 1;

  typedef struct {
    logic [7:0] data;
    logic       empty;
    logic       fe;
    logic       ov;
    int         tick;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] m_data = 8'h00;
  logic       m_empty = 1'b1;
  logic       m_fe = 1'b0;
  logic       m_ov = 1'b0;

  task automatic push_if_changed(input logic [10:0] old, input int tk);
    exp_t e;
    if (old !== {m_data, m_empty, m_fe, m_ov}) begin
      e.data = m_data; e.empty = m_empty; e.fe = m_fe; e.ov = m_ov; e.tick = tk;
      exp_q.push_back(e);
    end
  endtask

  // Outcome of one complete frame; uld marks an unload in the load cycle.
  task automatic model_frame(input logic [7:0] b, input logic stop, input bit uld, input int tk);
    logic [10:0] old;
    old = {m_data, m_empty, m_fe, m_ov};
    if (uld && !m_empty) begin
      m_empty = 1'b1; m_fe = 1'b0; m_ov = 1'b0;
    end
    if (stop) begin
      if (m_empty) begin m_data = b; m_empty = 1'b0; end
      else m_ov = 1'b1;
    end else begin
      m_fe = 1'b1;
    end
    push_if_changed(old, tk);
  endtask

  task automatic model_reset();
    logic [10:0] old;
    old = {m_data, m_empty, m_fe, m_ov};
    m_data = 8'h00; m_empty = 1'b1; m_fe = 1'b0; m_ov = 1'b0;
    push_if_changed(old, -1);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic wait_until(input int t);
    while (tick_cnt < t) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input bit uld_same, input bit do_model);
    int s;
    wait_until(tick_cnt + 1);
    s = tick_cnt;
    frame_s = s;
    if (do_model) model_frame(b, stop, uld_same, s + 153);
    ifc.i_rx = 1'b0;
    for (int k = 0; k < 8; k++) begin
      wait_until(s + 16 * (k + 1));
      ifc.i_rx = b[k];
    end
    wait_until(s + 144);
    ifc.i_rx = stop;
    if (uld_same) begin
      wait_until(s + 152);
      repeat (3) @(negedge clk);
      ifc.i_uld_rx_data = 1'b1;
      @(negedge clk);
      ifc.i_uld_rx_data = 1'b0;
    end
    wait_until(s + 160);
    ifc.i_rx = 1'b1;
    wait_until(s + 164);
  endtask

  task automatic do_unload();
    logic [10:0] old;
    old = {m_data, m_empty, m_fe, m_ov};
    if (!m_empty) begin
      m_empty = 1'b1; m_fe = 1'b0; m_ov = 1'b0;
    end
    push_if_changed(old, -1);
    ifc.i_uld_rx_data = 1'b1;
    @(negedge clk);
    ifc.i_uld_rx_data = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Monitor: every change of the holding-register outputs must match the
  // next predicted snapshot, at the predicted tick where one is given.
  initial begin
    logic [10:0] prev, cur;
    exp_t e;
    wait (mon_on);
    prev = {ifc.o_rx_data, ifc.o_rx_empty, ifc.o_rx_frame_err, ifc.o_rx_overrun};
    forever begin
      @(negedge clk);
      cur = {ifc.o_rx_data, ifc.o_rx_empty, ifc.o_rx_frame_err, ifc.o_rx_overrun};
      if (cur !== prev) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_update: got data=%0h empty=%0b fe=%0b ov=%0b at tick %0d",
                   cur[10:3], cur[2], cur[1], cur[0], tick_cnt);
        end else begin
          e = exp_q.pop_front();
          if (cur !== {e.data, e.empty, e.fe, e.ov} || (e.tick >= 0 && e.tick != tick_cnt)) begin
            bad++;
            $display("FAIL holding_reg: got data=%0h empty=%0b fe=%0b ov=%0b tick=%0d expected data=%0h empty=%0b fe=%0b ov=%0b tick=%0d",
                     cur[10:3], cur[2], cur[1], cur[0], tick_cnt,
                     e.data, e.empty, e.fe, e.ov, e.tick);
          end
        end
        prev = cur;
      end
    end
  end

  initial begin
    int s;
    ifc.i_rx = 1'b1;
    ifc.i_rx_en = 1'b1;
    ifc.i_uld_rx_data = 1'b0;
    repeat (5) @(negedge clk);
    check("reset_data",  32'(ifc.o_rx_data), 32'h00);
    check("reset_empty", 32'(ifc.o_rx_empty), 32'h1);
    check("reset_fe",    32'(ifc.o_rx_frame_err), 32'h0);
    check("reset_ov",    32'(ifc.o_rx_overrun), 32'h0);
    check("reset_busy",  32'(ifc.o_rx_busy), 32'h0);
    rst_n = 1'b1;
    mon_on = 1'b1;
    repeat (8) @(negedge clk);

    // valid frame then unload
    send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
    check("a5_data", 32'(ifc.o_rx_data), 32'hA5);
    do_unload();
    check("a5_unload_empty", 32'(ifc.o_rx_empty), 32'h1);

    // false start: low for 4 ticks only
    wait_until(tick_cnt + 1);
    s = tick_cnt;
    ifc.i_rx = 1'b0;
    wait_until(s + 2);
    check("fs_busy_rise", 32'(ifc.o_rx_busy), 32'h1);
    wait_until(s + 4);
    ifc.i_rx = 1'b1;
    wait_until(s + 8);
    check("fs_busy_hold", 32'(ifc.o_rx_busy), 32'h1);
    wait_until(s + 9);
    check("fs_busy_fall", 32'(ifc.o_rx_busy), 32'h0);
    check("fs_empty", 32'(ifc.o_rx_empty), 32'h1);
    wait_until(s + 40);

    // framing error, then a normal byte, then unload clears the flag
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
    send_frame(8'h55, 1'b1, 1'b0, 1'b1);
    check("fe_sticky", 32'(ifc.o_rx_frame_err), 32'h1);
    do_unload();
    check("fe_cleared", 32'(ifc.o_rx_frame_err), 32'h0);

    // overrun
    send_frame(8'h11, 1'b1, 1'b0, 1'b1);
    send_frame(8'h22, 1'b1, 1'b0, 1'b1);
    check("ov_data", 32'(ifc.o_rx_data), 32'h11);
    check("ov_flag", 32'(ifc.o_rx_overrun), 32'h1);
    do_unload();
    check("ov_cleared", 32'(ifc.o_rx_overrun), 32'h0);

    // unload in the exact load cycle
    send_frame(8'h66, 1'b1, 1'b0, 1'b1);
    send_frame(8'h77, 1'b1, 1'b1, 1'b1);
    check("sim_data", 32'(ifc.o_rx_data), 32'h77);
    check("sim_empty", 32'(ifc.o_rx_empty), 32'h0);
    check("sim_ov", 32'(ifc.o_rx_overrun), 32'h0);

    // reset during data bit 3, held until the frame has passed
    frame_s = -1;
    fork
      send_frame(8'hF0, 1'b1, 1'b0, 1'b0);
      begin
        while (frame_s < 0) @(negedge clk);
        wait_until(frame_s + 72);
        model_reset();
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(ifc.o_rx_busy), 32'h0);
        check("rst_empty", 32'(ifc.o_rx_empty), 32'h1);
      end
    join
    rst_n = 1'b1;
    repeat (8) @(negedge clk);

    // receiver disabled mid-frame: partial frame dropped
    frame_s = -1;
    fork
      send_frame(8'h99, 1'b1, 1'b0, 1'b0);
      begin
        while (frame_s < 0) @(negedge clk);
        wait_until(frame_s + 40);
        ifc.i_rx_en = 1'b0;
        wait_until(frame_s + 41);
        check("dis_busy", 32'(ifc.o_rx_busy), 32'h0);
      end
    join
    ifc.i_rx_en = 1'b1;
    check("dis_empty", 32'(ifc.o_rx_empty), 32'h1);

    send_frame(8'h81, 1'b1, 1'b0, 1'b1);
    check("after_abort_data", 32'(ifc.o_rx_data), 32'h81);
    do_unload();

    // random frames: random payload, occasional bad stop bit, random unloads
    for (int n = 0; n < 20; n++) begin
      logic [7:0] b;
      logic       stp;
      b   = 8'($urandom);
      stp = ($urandom_range(0, 4) != 0);
      send_frame(b, stp, 1'b0, 1'b1);
      if ($urandom_range(0, 1) == 1) do_unload();
      wait_until(tick_cnt + $urandom_range(0, 20));
    end

    repeat (20) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
